// File: rtl/onehot_ring_gen.sv
// Registered one-hot vector generator with rotate-on-command and a deliberate
// single-cycle two-hot fault mode, used to drive one-hot assertion checkers.
module onehot_ring_gen #(
    parameter int W  = 4,
    parameter int PW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          step_en,
    input  logic          inject,
    output logic          valid_o,
    output logic [W-1:0]  vec_o,
    output logic [PW-1:0] pos_o,
    output logic          wrap_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        INJECT = 2'd2
    } state_t;

    localparam logic [PW-1:0] LAST_POS = PW'(W - 1);
    localparam logic [W-1:0]  FIRST_BIT = W'(1);

    state_t        state_q, state_d;
    logic [W-1:0]  base_q, base_d;
    logic [W-1:0]  vec_q, vec_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          valid_q, valid_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;
    logic [W-1:0]  baseRotl;

    assign baseRotl = {base_q[W-2:0], base_q[W-1]};

    // Every output is computed here one cycle ahead and registered below,
    // so nothing combinational reaches the ports. Defaults clear everything,
    // which is also the IDLE/stop behaviour.
    always_comb begin
        state_d = IDLE;
        base_d  = '0;
        vec_d   = '0;
        pos_d   = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    base_d  = FIRST_BIT;
                    vec_d   = FIRST_BIT;
                    valid_d = 1'b1;
                end
            end

            RUN: begin
                if (!stop) begin
                    state_d = RUN;
                    base_d  = base_q;
                    vec_d   = base_q;
                    pos_d   = pos_q;
                    valid_d = 1'b1;
                    if (inject) begin
                        state_d = INJECT;
                        vec_d   = base_q | baseRotl;
                        err_d   = 1'b1;
                    end else if (step_en) begin
                        base_d = baseRotl;
                        vec_d  = baseRotl;
                        pos_d  = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
                        wrap_d = (pos_q == LAST_POS);
                    end
                end
            end

            INJECT: begin
                // Fault lasts exactly one cycle; step_en and inject are ignored here.
                if (!stop) begin
                    state_d = RUN;
                    base_d  = base_q;
                    vec_d   = base_q;
                    pos_d   = pos_q;
                    valid_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            vec_q   <= '0;
            pos_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            vec_q   <= vec_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q;
    assign vec_o   = vec_q;
    assign pos_o   = pos_q;
    assign wrap_o  = wrap_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_onehot_ring_gen.sv
// Directed testbench for onehot_ring_gen at W=4 with hand-computed expected
// vectors covering start, walk/wrap, fault injection, priority and async reset.
module tb_onehot_ring_gen;

    localparam int W  = 4;
    localparam int PW = $clog2(W);

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic          step_en;
    logic          inject;
    logic          valid_o;
    logic [W-1:0]  vec_o;
    logic [PW-1:0] pos_o;
    logic          wrap_o;
    logic          err_o;

    int testCount = 0;
    int failCount = 0;
    int violations;

    onehot_ring_gen #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .step_en (step_en),
        .inject  (inject),
        .valid_o (valid_o),
        .vec_o   (vec_o),
        .pos_o   (pos_o),
        .wrap_o  (wrap_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic expValid,
                            input logic [W-1:0] expVec, input logic [PW-1:0] expPos,
                            input logic expWrap, input logic expErr);
        checkOutput({tag, ".valid"}, 32'(valid_o), 32'(expValid));
        checkOutput({tag, ".vec"},   32'(vec_o),   32'(expVec));
        checkOutput({tag, ".pos"},   32'(pos_o),   32'(expPos));
        checkOutput({tag, ".wrap"},  32'(wrap_o),  32'(expWrap));
        checkOutput({tag, ".err"},   32'(err_o),   32'(expErr));
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic applyStimulus(input logic iStart, input logic iStop,
                                 input logic iStep, input logic iInject);
        @(negedge clk);
        start   = iStart;
        stop    = iStop;
        step_en = iStep;
        inject  = iInject;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; step_en = 1'b0; inject = 1'b0;

        // Reset and start
        #1 rst = 1'b1;
        #2;
        checkAll("reset", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkAll("idleIgnore", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("start", 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("hold", 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);

        // Walk and wrap
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("walk1", 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("walk2", 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("walk3", 1'b1, 4'b1000, 2'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("walk4wrap", 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkAll("walk5", 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);

        // Fault injection from 0100, with step_en held through INJECT
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("preInject", 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0);
        violations = (valid_o && !$onehot(vec_o)) ? 1 : 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkAll("inject", 1'b1, 4'b1100, 2'd2, 1'b0, 1'b1);
        violations += (valid_o && !$onehot(vec_o)) ? 1 : 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("postInject", 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0);
        violations += (valid_o && !$onehot(vec_o)) ? 1 : 0;
        checkOutput("oneHotViolations", 32'(violations), 32'd1);

        // Priority: stop beats inject and step_en; start+stop stays IDLE
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkAll("stopPriority", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkAll("startStop", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("restart", 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);

        // Held inject alternates INJECT and RUN
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("held1", 1'b1, 4'b0011, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("held2", 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("held3", 1'b1, 4'b0011, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("held4", 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);

        // Stop during INJECT clears outputs
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("injectAgain", 1'b1, 4'b0011, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkAll("stopInInject", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Reset mid-run at 1000
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("preReset", 1'b1, 4'b1000, 2'd3, 1'b0, 1'b0);
        step_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkAll("asyncReset", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("startAfterReset", 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
